// File: rtl/noc_msg_rx_parser_if.sv
// Handshake bundle for the NoC message RX parser.
// The slave modport is the parser's view: it receives flits and produces
// the header and body streams. The master modport is the opposite side
// (router plus downstream engine).
interface noc_msg_rx_parser_if #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 8
);
  logic              noc_in_val;
  logic [DATA_W-1:0] noc_in_data;
  logic              noc_in_rdy;

  logic              hdr_out_val;
  logic [DATA_W-1:0] hdr_out;
  logic [LEN_W-1:0]  hdr_out_body_len;
  logic              hdr_out_rdy;

  logic              body_out_val;
  logic [DATA_W-1:0] body_out_data;
  logic              body_out_last;
  logic              body_out_rdy;

  modport master (
    output noc_in_val, noc_in_data, hdr_out_rdy, body_out_rdy,
    input  noc_in_rdy, hdr_out_val, hdr_out, hdr_out_body_len,
           body_out_val, body_out_data, body_out_last
  );

  modport slave (
    input  noc_in_val, noc_in_data, hdr_out_rdy, body_out_rdy,
    output noc_in_rdy, hdr_out_val, hdr_out, hdr_out_body_len,
           body_out_val, body_out_data, body_out_last
  );
endinterface

// File: rtl/noc_msg_rx_parser.sv
// Receive-side parser for beehive NoC messages.
// Captures the header flit into a register, offers it on the header port,
// then passes the msg_len body flits straight through with a last marker.
// Optional feature: define NOC_RX_TYPE_CHECK_EN to drop messages whose
// msg_type differs from EXP_MSG_TYPE and count them in drop_cnt.
// Header layout (top BASE_FLIT_W bits of the flit, MSB first):
//   dst_x[8] dst_y[8] dst_fbits[4] msg_len[LEN] msg_type[8]
//   src_x[8] src_y[8] src_fbits[4] rsvd[8]
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 128
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif
`ifndef ETH_RX_FRAME
`define ETH_RX_FRAME 12
`endif

module noc_msg_rx_parser #(
  parameter int NOC_DATA_W   = `NOC_DATA_WIDTH,
  parameter int EXP_MSG_TYPE = `ETH_RX_FRAME,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_msg_rx_parser_if.slave   bus,
  output logic [ERR_CNT_W-1:0] drop_cnt
);

  localparam int LEN_W       = `MSG_LENGTH_WIDTH;
  localparam int BASE_FLIT_W = 56 + LEN_W;
  localparam int LEN_LSB     = NOC_DATA_W - 20 - LEN_W;
  localparam int TYPE_LSB    = LEN_LSB - 8;

  typedef enum logic [1:0] {
    HDR_WAIT,
    HDR_OUT,
    BODY,
    DROP
  } state_t;

  state_t                state_q, state_d;
  logic [NOC_DATA_W-1:0] hdr_q;
  logic [LEN_W-1:0]      body_cnt_q, body_cnt_d;
  logic                  hdr_load;
  logic                  type_ok;
  logic [LEN_W-1:0]      msg_len_in;

  assign msg_len_in            = bus.noc_in_data[LEN_LSB +: LEN_W];
  assign bus.hdr_out           = hdr_q;
  assign bus.hdr_out_body_len  = hdr_q[LEN_LSB +: LEN_W];
  assign bus.body_out_data     = bus.noc_in_data;

`ifdef NOC_RX_TYPE_CHECK_EN
  localparam logic [7:0] EXP_TYPE = EXP_MSG_TYPE[7:0];
  logic drop_hdr;
  logic [ERR_CNT_W-1:0] drop_cnt_q;

  assign type_ok  = (bus.noc_in_data[TYPE_LSB +: 8] == EXP_TYPE);
  assign drop_hdr = (state_q == HDR_WAIT) && bus.noc_in_val && bus.noc_in_rdy && !type_ok;
  assign drop_cnt = drop_cnt_q;

  // Count rejected headers, sticking at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop_hdr && (drop_cnt_q != {ERR_CNT_W{1'b1}})) begin
      drop_cnt_q <= drop_cnt_q + ERR_CNT_W'(1);
    end
  end
`else
  // Every header is accepted; the expected type is folded in only so it
  // stays referenced, the result is always true
  assign type_ok  = 1'b1 | (EXP_MSG_TYPE != 0);
  assign drop_cnt = '0;
`endif

  // State, captured header and remaining-body counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR_WAIT;
      hdr_q      <= '0;
      body_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      body_cnt_q <= body_cnt_d;
      if (hdr_load) begin
        hdr_q <= bus.noc_in_data;
      end
    end
  end

  // Next state and handshake outputs; everything is held low during reset
  always_comb begin
    state_d           = state_q;
    body_cnt_d        = body_cnt_q;
    hdr_load          = 1'b0;
    bus.noc_in_rdy    = 1'b0;
    bus.hdr_out_val   = 1'b0;
    bus.body_out_val  = 1'b0;
    bus.body_out_last = 1'b0;
    if (!rst) begin
      case (state_q)
        HDR_WAIT: begin
          bus.noc_in_rdy = 1'b1;
          if (bus.noc_in_val) begin
            hdr_load   = 1'b1;
            body_cnt_d = msg_len_in;
            state_d    = type_ok ? HDR_OUT : DROP;
          end
        end
        HDR_OUT: begin
          bus.hdr_out_val = 1'b1;
          if (bus.hdr_out_rdy) begin
            state_d = (body_cnt_q == '0) ? HDR_WAIT : BODY;
          end
        end
        BODY: begin
          if (body_cnt_q == '0) begin
            state_d = HDR_WAIT;
          end else begin
            bus.body_out_val  = bus.noc_in_val;
            bus.noc_in_rdy    = bus.body_out_rdy;
            bus.body_out_last = (body_cnt_q == LEN_W'(1));
            if (bus.noc_in_val && bus.body_out_rdy) begin
              body_cnt_d = body_cnt_q - LEN_W'(1);
              if (body_cnt_q == LEN_W'(1)) begin
                state_d = HDR_WAIT;
              end
            end
          end
        end
        DROP: begin
          if (body_cnt_q == '0) begin
            state_d = HDR_WAIT;
          end else begin
            bus.noc_in_rdy = 1'b1;
            if (bus.noc_in_val) begin
              body_cnt_d = body_cnt_q - LEN_W'(1);
              if (body_cnt_q == LEN_W'(1)) begin
                state_d = HDR_WAIT;
              end
            end
          end
        end
        default: state_d = HDR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_msg_rx_parser.sv
// Self-checking bench for noc_msg_rx_parser.
// A message-level model (pending header, remaining body flits, dropping)
// predicts every output each cycle; directed cases pin the model with
// hand-computed literals, then a randomized run stresses backpressure.
// Build with NOC_RX_TYPE_CHECK_EN defined to also exercise the drop path.
module tb_noc_msg_rx_parser;

  localparam int DW       = 128;
  localparam int LW       = 8;
  localparam int EW       = 16;
  localparam int LEN_LSB  = 100;
  localparam int TYPE_LSB = 92;
  localparam int EXP_T    = 12;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [EW-1:0] drop_cnt;

  noc_msg_rx_parser_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

  noc_msg_rx_parser #(
    .NOC_DATA_W  (DW),
    .EXP_MSG_TYPE(EXP_T),
    .ERR_CNT_W   (EW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int val_pct  = 100;
  int hdr_pct  = 100;
  int body_pct = 100;
  bit body_tog = 1'b0;
  bit tog_state = 1'b0;

  logic [DW-1:0] stream[$];
  beat_t         body_log[$];
  logic [DW-1:0] hdr_log[$];
  int            acc_cyc[$];
  int            hs_cyc[$];

  bit            m_pend, m_body, m_drop;
  logic [DW-1:0] m_hdr;
  int            m_remaining;
  int            m_drop_cnt;

  // Report one comparison
  task automatic compare(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_hdr(int len, int typ);
    logic [DW-1:0] h;
    h = {$urandom(), $urandom(), $urandom(), $urandom()};
    h[LEN_LSB +: LW] = LW'(len);
    h[TYPE_LSB +: 8] = 8'(typ);
    return h;
  endfunction

  function automatic bit model_idle();
    return !m_pend && !m_body && !m_drop;
  endfunction

  function automatic void clear_logs();
    body_log.delete();
    hdr_log.delete();
    acc_cyc.delete();
    hs_cyc.delete();
  endfunction

  // Compare every DUT output against what the model says this cycle must show
  task automatic check_output();
    compare("drop_cnt", drop_cnt, m_drop_cnt);
    if (m_pend) begin
      compare("hdr_val", bus.hdr_out_val, 1);
      compare("hdr_in_rdy", bus.noc_in_rdy, 0);
      compare("hdr_body_val", bus.body_out_val, 0);
      compare("hdr_last", bus.body_out_last, 0);
      compare("hdr_out", bus.hdr_out, m_hdr);
      compare("hdr_len", bus.hdr_out_body_len, m_hdr[LEN_LSB +: LW]);
    end else if (m_body) begin
      compare("body_hdr_val", bus.hdr_out_val, 0);
      compare("body_val", bus.body_out_val, bus.noc_in_val);
      compare("body_in_rdy", bus.noc_in_rdy, bus.body_out_rdy);
      compare("body_last", bus.body_out_last, (m_remaining == 1));
      if (bus.noc_in_val) compare("body_data", bus.body_out_data, bus.noc_in_data);
    end else if (m_drop) begin
      compare("drop_hdr_val", bus.hdr_out_val, 0);
      compare("drop_body_val", bus.body_out_val, 0);
      compare("drop_last", bus.body_out_last, 0);
      compare("drop_in_rdy", bus.noc_in_rdy, (m_remaining != 0));
    end else begin
      compare("idle_in_rdy", bus.noc_in_rdy, 1);
      compare("idle_hdr_val", bus.hdr_out_val, 0);
      compare("idle_body_val", bus.body_out_val, 0);
      compare("idle_last", bus.body_out_last, 0);
    end
  endtask

  // Advance the message-level model by the transfers this cycle will make
  task automatic update_model();
    logic          v;
    logic [DW-1:0] d;
    bit            ok;
    beat_t         b;
    v = bus.noc_in_val;
    d = bus.noc_in_data;
    if (m_pend) begin
      if (bus.hdr_out_rdy) begin
        m_pend = 1'b0;
        hs_cyc.push_back(cyc);
        hdr_log.push_back(m_hdr);
        if (m_remaining > 0) m_body = 1'b1;
      end
    end else if (m_body) begin
      if (v && bus.body_out_rdy) begin
        b.data = d;
        b.last = (m_remaining == 1);
        body_log.push_back(b);
        void'(stream.pop_front());
        m_remaining--;
        if (m_remaining == 0) m_body = 1'b0;
      end
    end else if (m_drop) begin
      if (m_remaining == 0) begin
        m_drop = 1'b0;
      end else if (v) begin
        void'(stream.pop_front());
        m_remaining--;
        if (m_remaining == 0) m_drop = 1'b0;
      end
    end else if (v) begin
      void'(stream.pop_front());
      acc_cyc.push_back(cyc);
      m_hdr       = d;
      m_remaining = int'(d[LEN_LSB +: LW]);
`ifdef NOC_RX_TYPE_CHECK_EN
      ok = (d[TYPE_LSB +: 8] == 8'(EXP_T));
`else
      ok = 1'b1;
`endif
      if (ok) begin
        m_pend = 1'b1;
      end else begin
        m_drop = 1'b1;
        if (m_drop_cnt < (2 ** EW) - 1) m_drop_cnt++;
      end
    end
  endtask

  // One clock cycle: drive at negedge, check just before the posedge
  task automatic apply_stimulus();
    @(negedge clk);
    cyc++;
    bus.noc_in_val  = (stream.size() > 0) && ($urandom_range(99) < val_pct);
    bus.noc_in_data = bus.noc_in_val ? stream[0]
                                     : {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.hdr_out_rdy = ($urandom_range(99) < hdr_pct);
    if (body_tog) begin
      tog_state        = ~tog_state;
      bus.body_out_rdy = tog_state;
    end else begin
      bus.body_out_rdy = ($urandom_range(99) < body_pct);
    end
    #3;
    check_output();
    update_model();
  endtask

  task automatic run_until_idle(int bound);
    int n = 0;
    while ((stream.size() > 0 || !model_idle()) && n < bound) begin
      apply_stimulus();
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("[TB] FAIL run_timeout at cycle %0d: got %0d cycles, expected fewer than %0d", cyc, n, bound);
    end
  endtask

  // Hold reset for three cycles and check the reset values from the second on
  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cyc++;
      rst              = 1'b1;
      bus.noc_in_val   = 1'b0;
      bus.noc_in_data  = '0;
      bus.hdr_out_rdy  = 1'b0;
      bus.body_out_rdy = 1'b0;
      #3;
      if (i > 0) begin
        compare("rst_in_rdy", bus.noc_in_rdy, 0);
        compare("rst_hdr_val", bus.hdr_out_val, 0);
        compare("rst_body_val", bus.body_out_val, 0);
        compare("rst_last", bus.body_out_last, 0);
        compare("rst_hdr_out", bus.hdr_out, 0);
        compare("rst_drop_cnt", drop_cnt, 0);
      end
    end
    stream.delete();
    m_pend = 1'b0; m_body = 1'b0; m_drop = 1'b0;
    m_remaining = 0; m_drop_cnt = 0; m_hdr = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_msg(logic [DW-1:0] hdr);
    int len;
    len = int'(hdr[LEN_LSB +: LW]);
    stream.push_back(hdr);
    for (int i = 0; i < len; i++)
      stream.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  initial begin
    logic [DW-1:0] h;
    int            n;
    int            len;

    do_reset();

    // Zero-length messages back to back: header latency and re-accept spacing
    clear_logs();
    stream.push_back(128'hABCDE000C123456789ABCDEF01234567);
    stream.push_back(128'h1111100_0C_00000000000000000000000);
    run_until_idle(50);
    compare("len0_hdr_latency", hs_cyc[0] - acc_cyc[0], 1);
    compare("len0_next_accept", acc_cyc[1] - acc_cyc[0], 2);
    compare("len0_no_body", body_log.size(), 0);
    h = hdr_log[0];
    compare("len0_len_field", h[LEN_LSB +: LW], 0);

    // Three-flit body, everything ready
    clear_logs();
    stream.push_back(128'hABCDE030C123456789ABCDEF01234567);
    stream.push_back(128'hD0);
    stream.push_back(128'hD1);
    stream.push_back(128'hD2);
    run_until_idle(50);
    h = hdr_log[0];
    compare("len3_len_field", h[LEN_LSB +: LW], 3);
    compare("len3_beats", body_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      compare("len3_data", body_log[i].data, 128'hD0 + 128'(i));
      compare("len3_last", body_log[i].last, (i == 2));
    end

    // Header held off for five cycles before the body may start
    clear_logs();
    push_msg(mk_hdr(2, EXP_T));
    hdr_pct = 0;
    for (int i = 0; i < 6; i++) apply_stimulus();
    compare("hold_accepts", acc_cyc.size(), 1);
    compare("hold_no_hs", hs_cyc.size(), 0);
    compare("hold_no_body", body_log.size(), 0);
    hdr_pct = 100;
    run_until_idle(50);
    compare("hold_beats", body_log.size(), 2);
    compare("hold_last", body_log[1].last, 1);

    // Body ready toggling every cycle
    clear_logs();
    stream.push_back(mk_hdr(4, EXP_T));
    for (int i = 0; i < 4; i++) stream.push_back(128'h50 + 128'(i));
    body_tog  = 1'b1;
    tog_state = 1'b0;
    run_until_idle(50);
    body_tog = 1'b0;
    compare("tog_beats", body_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      compare("tog_data", body_log[i].data, 128'h50 + 128'(i));
      compare("tog_last", body_log[i].last, (i == 3));
    end

`ifdef NOC_RX_TYPE_CHECK_EN
    // Wrong-type message is swallowed, the next one goes through
    clear_logs();
    push_msg(mk_hdr(4, 13));
    push_msg(mk_hdr(1, EXP_T));
    run_until_idle(50);
    compare("drop_model_cnt", m_drop_cnt, 1);
    compare("drop_dut_cnt", drop_cnt, 1);
    compare("drop_hdrs", hdr_log.size(), 1);
    compare("drop_beats", body_log.size(), 1);
`endif

    // Reset after the first of three body beats
    clear_logs();
    push_msg(mk_hdr(3, EXP_T));
    n = 0;
    while (body_log.size() < 1 && n < 50) begin
      apply_stimulus();
      n++;
    end
    compare("mid_rst_one_beat", body_log.size(), 1);
    do_reset();
    clear_logs();
    stream.push_back(mk_hdr(0, EXP_T));
    run_until_idle(50);
    compare("mid_rst_new_hdr", hdr_log.size(), 1);
    compare("mid_rst_no_body", body_log.size(), 0);

    // Randomized traffic with backpressure on every port, incl. a 255 body
    clear_logs();
    val_pct  = 70;
    hdr_pct  = 60;
    body_pct = 60;
    for (int m = 0; m < 40; m++) begin
      if (m == 20) len = 255;
      else if ($urandom_range(9) < 7) len = $urandom_range(4);
      else len = $urandom_range(12);
`ifdef NOC_RX_TYPE_CHECK_EN
      push_msg(mk_hdr(len, ($urandom_range(3) == 0) ? 13 + $urandom_range(20) : EXP_T));
`else
      push_msg(mk_hdr(len, $urandom_range(255)));
`endif
    end
    run_until_idle(20000);
    compare("rand_hdrs_plus_drops", hdr_log.size() + m_drop_cnt, 40);

`ifndef NOC_RX_TYPE_CHECK_EN
    compare("no_drops", drop_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case something above stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
